// File: rtl/rr_req_arbiter.sv
// Registered round-robin arbiter feeding a one-hot encoder stage.
// Grants are held until ack, withdrawal, disable or an optional hold timeout.
module rr_req_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N-1:0]           req,
  input  logic                   ack,
  output logic [N-1:0]           grant,
  output logic                   busy,
  output logic                   timeout,
  output logic [$clog2(N)-1:0]   last_idx
);

  localparam int IW = $clog2(N);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_r;
  logic [N-1:0]    grant_r;
  logic            busy_r;
  logic            timeout_r;
  logic [IW-1:0]   last_idx_r;
  logic [IW-1:0]   gidx_r;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_next_s;
  logic            win_found_s;
  logic [IW-1:0]   win_idx_s;
  logic            hit_timeout_s;

  // Rotating-priority scan: first set request above the last completed index.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IW{1'b0}};
    for (int k = 1; k <= N; k++) begin
      int cand;
      cand = (int'(last_idx_r) + k) % N;
      if (!win_found_s && req[cand]) begin
        win_found_s = 1'b1;
        win_idx_s   = IW'(cand);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Hold counter lookahead: the value it would take at this edge.
  always_comb begin
    cnt_next_s    = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    hit_timeout_s = (TIMEOUT != 0) && (cnt_next_s == CW'(TIMEOUT));
  end

  // Arbiter state, grant register and hold counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      grant_r    <= {N{1'b0}};
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
      last_idx_r <= IW'(N - 1);
      gidx_r     <= {IW{1'b0}};
      cnt_r      <= {CW{1'b0}};
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (en && win_found_s) begin
            state_r <= GRANT;
            grant_r <= {{(N-1){1'b0}}, 1'b1} << win_idx_s;
            busy_r  <= 1'b1;
            gidx_r  <= win_idx_s;
            cnt_r   <= {CW{1'b0}};
          end
        end
        GRANT: begin
          if (!en) begin
            state_r <= IDLE;
            grant_r <= {N{1'b0}};
            busy_r  <= 1'b0;
          end else if (ack || !req[gidx_r]) begin
            state_r    <= IDLE;
            grant_r    <= {N{1'b0}};
            busy_r     <= 1'b0;
            last_idx_r <= gidx_r;
          end else if (hit_timeout_s) begin
            state_r    <= IDLE;
            grant_r    <= {N{1'b0}};
            busy_r     <= 1'b0;
            last_idx_r <= gidx_r;
            timeout_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_next_s;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= {N{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = grant_r;
  assign busy     = busy_r;
  assign timeout  = timeout_r;
  assign last_idx = last_idx_r;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Self-checking bench for rr_req_arbiter: directed scenarios plus random traffic
// against a cycle-level behavioural model of the arbitration rules.
module tb_rr_req_arbiter;

  localparam int N  = 4;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] req;
  logic         ack;
  logic [N-1:0] grant;
  logic         busy;
  logic         timeout;
  logic [1:0]   last_idx;

  int n_cmp = 0;
  int n_err = 0;

  // Model: granted index (-1 when idle), cycles the grant has been visible.
  int m_gi, m_hold, m_last;
  bit m_to;

  rr_req_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
    .grant(grant), .busy(busy), .timeout(timeout), .last_idx(last_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gi = -1; m_hold = 0; m_last = N - 1; m_to = 1'b0;
  endtask

  task automatic model_step();
    m_to = 1'b0;
    if (m_gi < 0) begin
      if (en && req != 4'b0000) begin
        for (int k = 1; k <= N; k++) begin
          if (m_gi < 0 && req[(m_last + k) % N]) m_gi = (m_last + k) % N;
        end
        m_hold = 1;
      end
    end else if (!en) begin
      m_gi = -1;
    end else if (ack || !req[m_gi]) begin
      m_last = m_gi; m_gi = -1;
    end else if (TO != 0 && m_hold == TO) begin
      m_last = m_gi; m_gi = -1; m_to = 1'b1;
    end else begin
      m_hold++;
    end
  endtask

  task automatic check_all();
    int enc;
    int exp_g;
    exp_g = (m_gi < 0) ? 0 : (1 << m_gi);
    chk("grant", int'(grant), exp_g);
    chk("busy", int'(busy), (m_gi < 0) ? 0 : 1);
    chk("timeout", int'(timeout), int'(m_to));
    chk("last_idx", int'(last_idx), m_last);
    chk("onehot0", int'($onehot0(grant)), 1);
    if (grant != 4'b0000) begin
      enc = -1;
      for (int i = 0; i < N; i++) if (grant[i]) enc = i;
      chk("encoder_idx", enc, m_gi);
    end
  endtask

  task automatic cyc(input logic e, input logic [N-1:0] r, input logic a);
    @(negedge clk);
    en = e; req = r; ack = a;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; req = 4'b0000; ack = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [N-1:0] seq_exp [9];
  int hold_cnt, saved_last;
  logic [N-1:0] r_rand;

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0000; ack = 1'b0;
    model_reset();
    #12;
    chk("init_grant", int'(grant), 0);
    chk("init_last", int'(last_idx), 3);
    chk("init_timeout", int'(timeout), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single request, held, then acked.
    cyc(1'b1, 4'b0001, 1'b0);
    chk("s1_grant", int'(grant), 1);
    repeat (3) cyc(1'b1, 4'b0001, 1'b0);
    cyc(1'b1, 4'b0001, 1'b1);
    chk("s1_release", int'(grant), 0);
    chk("s1_last", int'(last_idx), 0);

    // All requesting with ack pulsed: full rotation with bubbles.
    do_reset();
    seq_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 4'b1111, 1'b1);
      chk($sformatf("rot%0d", i), int'(grant), int'(seq_exp[i]));
    end

    // Enable gating and abort.
    cyc(1'b0, 4'b0100, 1'b0);
    cyc(1'b0, 4'b0100, 1'b0);
    chk("en0_grant", int'(grant), 0);
    cyc(1'b1, 4'b0100, 1'b0);
    chk("en1_grant", int'(grant), 4);
    saved_last = int'(last_idx);
    cyc(1'b0, 4'b0100, 1'b0);
    chk("abort_grant", int'(grant), 0);
    chk("abort_last", int'(last_idx), saved_last);

    // Timeout: grant visible exactly TO cycles, then a one-cycle pulse.
    do_reset();
    hold_cnt = 0;
    cyc(1'b1, 4'b0010, 1'b0);
    while (grant == 4'b0010 && hold_cnt < 20) begin
      hold_cnt++;
      cyc(1'b1, 4'b0010, 1'b0);
    end
    chk("to_len", hold_cnt, TO);
    chk("to_pulse", int'(timeout), 1);
    chk("to_last", int'(last_idx), 1);
    cyc(1'b1, 4'b0110, 1'b0);
    chk("to_next_grant", int'(grant), 4);
    chk("to_pulse_end", int'(timeout), 0);

    // Ack on the timeout edge wins.
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0010, 1'b0);
    repeat (TO - 1) cyc(1'b1, 4'b0010, 1'b0);
    chk("pre_ack_grant", int'(grant), 2);
    cyc(1'b1, 4'b0010, 1'b1);
    chk("ack_to_grant", int'(grant), 0);
    chk("ack_to_pulse", int'(timeout), 0);

    // Requester withdraws mid-grant.
    cyc(1'b1, 4'b1000, 1'b0);
    chk("wd_grant", int'(grant), 8);
    cyc(1'b1, 4'b1000, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0);
    chk("wd_release", int'(grant), 0);
    chk("wd_last", int'(last_idx), 3);

    // Reset mid-grant drops grant asynchronously.
    cyc(1'b1, 4'b1000, 1'b0);
    chk("pre_rst_grant", int'(grant), 8);
    do_reset();
    chk("rst_timeout", int'(timeout), 0);
    cyc(1'b1, 4'b1000, 1'b0);
    chk("post_rst_grant", int'(grant), 8);

    // Random traffic with sticky requests so some grants time out.
    r_rand = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r_rand = 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 15) != 0), r_rand, ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_req_arbiter.md
Name: rr_req_arbiter

Overview:
- Registered round-robin arbiter in front of the 4-to-2 encoder stage.
- Takes up to N raw request lines and issues a one-hot grant vector, held until the consumer acknowledges.
- Guarantees the encoder input is always zero or exactly one-hot.
- Rotating priority prevents starvation; an optional timeout reclaims stuck grants.

Parameters:
N, 4, number of request lines (encoder width; only 4 is required to be supported)
TIMEOUT, 15, max cycles a grant is held without release; 0 disables the timeout

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
en  input  1  arbiter enable; feeds the encoder E in parallel
req  input  N  request lines, level-sensitive, bit i = requester i
ack  input  1  consumer done with current grant, sampled on clk
grant  output  N  registered one-hot grant (encoder I input); all-zero when idle
busy  output  1  1 while a grant is held (state GRANT)
timeout  output  1  one-cycle pulse when a grant is reclaimed by timeout
last_idx  output  log2(N)  index of the most recently completed grant

Behaviour:
- Reset (async, immediate):
  - grant=0, busy=0, timeout=0, last_idx=N-1, hold counter=0, state=IDLE.
  - last_idx=N-1 gives req[0] highest priority first.
- States:
  - IDLE: grant=0, busy=0.
  - GRANT: grant=one-hot, busy=1.
- IDLE -> GRANT:
  - Taken when en=1 and req!=0 at a rising edge.
  - Winner is the first set req bit scanning upward from last_idx+1 modulo N.
  - grant and busy become valid after that same edge (1-cycle latency from req to grant).
- GRANT holds grant constant. Release conditions, evaluated each edge, highest priority first:
  1. en=0: abort. Next state IDLE, grant=0, last_idx unchanged, no timeout pulse.
  2. ack=1: normal completion. IDLE, grant=0, last_idx := granted index.
  3. req[granted]=0: requester withdrew. Treated as completion; last_idx := granted index.
  4. Hold counter reaches TIMEOUT (TIMEOUT!=0): IDLE, grant=0, last_idx := granted index, timeout=1 for exactly one cycle.
- Hold counter:
  - Cleared on entry to GRANT.
  - Increments once per GRANT edge; counts the cycles the grant has been visible.
  - Release on timeout occurs at the edge where the count equals TIMEOUT, i.e. the grant is visible for exactly TIMEOUT cycles.
  - Counter width is ceil(log2(TIMEOUT+1)) minimum; it must not wrap before the comparison.
- After any release there is always at least one IDLE cycle with grant=0 before the next grant (bubble for the encoder V to drop).
- ack while IDLE is ignored. Changes in non-granted req bits during GRANT are ignored.
- Simultaneous ack and timeout on the same edge: ack wins, timeout stays 0.
- A single requester held high continuously is re-granted every second cycle when ack pulses each grant cycle.
- Invariant: grant is always 0 or one-hot; $onehot0(grant) holds every cycle, including across reset release.
- Reset asserted mid-GRANT: grant drops immediately (asynchronously), with no timeout pulse.

Test Plan:
- Reset then req=0001, en=1 -> grant=0001 one cycle later, busy=1. Hold ack=0 with req held: grant stays 0001. ack=1 for one cycle -> next cycle grant=0000, last_idx=0.
- req=1111 steady, ack pulsed in every grant cycle -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001. No requester is skipped.
- en=0 with req=0100 -> grant stays 0000. Raise en -> grant=0100. Drop en mid-grant -> grant=0000 next cycle, last_idx unchanged.
- TIMEOUT=15, req=0010 held, ack=0 -> grant=0010 for exactly 15 cycles, then grant=0000 with timeout=1 for one cycle. Next grant goes to the next requester after index 1.
- ack asserted on the same edge the counter reaches TIMEOUT -> grant=0000, timeout stays 0. Separately, req[granted] dropped mid-grant -> release next cycle, last_idx updated.
- Assert rst mid-GRANT (grant=1000) -> grant=0000, busy=0 immediately. After release with req=1000 -> grant=1000 again.
- Throughout all scenarios the bench checks that grant is one-hot or zero, and that the encoder driven by grant reports the index matching the granted bit.
